// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//   DATA_W            byte width carried to the transmitter
//   DEF_NUM_REQ       default number of requesters
//   DEF_TIMEOUT_CYCLES default watchdog limit while waiting for tx_done
//   arb_state_e       arbiter FSM states
//   wrap_inc()        modulo-n increment used for the round-robin pointer
package uart_tx_arbiter_pkg;

    localparam int unsigned DATA_W             = 8;
    localparam int unsigned DEF_NUM_REQ        = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 120000;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_DONE = 1'b1
    } arb_state_e;

    // idx+1 modulo n, for idx in [0, n-1]
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req      in   NUM_REQ  request vector
//   rr_ptr   in   IDX_W    highest-priority index this round
//   winner_c out  IDX_W    first set req scanning upward from rr_ptr with wrap
//   valid_c  out  1        any request present
module uart_tx_arbiter_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner_c,
    output logic               valid_c
);

    int unsigned idx;

    // Scan offsets 0..NUM_REQ-1 from rr_ptr; the first hit wins
    always_comb begin
        winner_c = '0;
        valid_c  = 1'b0;
        idx      = 32'd0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = 32'(rr_ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!valid_c && req[IDX_W'(idx)]) begin
                valid_c  = 1'b1;
                winner_c = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          level requests, one per source
//   req_data     byte i on bits [8*i+7:8*i]
//   gnt          one-hot pulse: byte latched, source may move on
//   done         one-hot pulse: byte fully sent
//   tx_start     one-cycle start pulse to the transmitter
//   tx_data      byte to the transmitter, held while sending
//   tx_done      transmitter completion pulse
//   busy         high while a byte is in flight
//   timeout_err  pulse when the transmitter never reports completion
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;
    logic                timeout_q, timeout_d;

    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [DATA_W-1:0]   sel_data;
    logic [IDX_W-1:0]    next_ptr;

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .rr_ptr   (rr_ptr_q),
        .winner_c (pick_idx),
        .valid_c  (pick_valid)
    );

    // Byte belonging to the current round-robin winner
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_data = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    // Pointer moves past the source just served, whether it completed or timed out
    assign next_ptr = IDX_W'(wrap_inc(32'(cur_idx_q), NUM_REQ));

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cur_idx_d  = cur_idx_q;
        tx_data_d  = tx_data_q;
        wdog_d     = wdog_q;
        gnt_d      = '0;
        done_d     = '0;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    cur_idx_d  = pick_idx;
                    tx_data_d  = sel_data;
                    tx_start_d = 1'b1;
                    gnt_d      = NUM_REQ'(1) << pick_idx;
                    wdog_d     = '0;
                    state_d    = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (wdog_q != WD_MAX) begin
                    wdog_d = wdog_q + WD_W'(1);
                end
                // tx_done has priority over a coincident watchdog expiry
                if (tx_done) begin
                    done_d   = NUM_REQ'(1) << cur_idx_q;
                    rr_ptr_d = next_ptr;
                    state_d  = ST_IDLE;
                end else if (wdog_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    rr_ptr_d  = next_ptr;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            cur_idx_q  <= '0;
            tx_data_q  <= '0;
            wdog_q     <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_idx_q  <= cur_idx_d;
            tx_data_q  <= tx_data_d;
            wdog_q     <= wdog_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a transaction-level model predicts every
// output each cycle, a stub transmitter answers tx_start with tx_done after one frame,
// and directed scenarios pin grant order, latencies and reset behaviour.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned TIMEOUT = 400;
    localparam int unsigned TX_LAT  = 160;   // 10 bits * 16 clocks per bit

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit model_on   = 1'b0;
    bit tx_en      = 1'b1;
    bit force_done = 1'b0;
    int gnt1_cnt   = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({gnt, done, tx_start, tx_data, busy, timeout_err});
    endfunction

    function automatic int oh2i(input logic [3:0] g);
        for (int i = 0; i < 4; i++) begin
            if (g[i]) return i;
        end
        return -1;
    endfunction

    // Stub transmitter: one frame after tx_start it pulses tx_done (if enabled)
    initial begin
        int cnt;
        cnt     = 0;
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = force_done;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0 && tx_en) tx_done = 1'b1;
                end
                if (tx_start) cnt = TX_LAT;
            end
        end
    end

    // Transaction model: one owner at a time, round-robin hand-off, watchdog by age
    logic [3:0] e_gnt, e_done;
    logic       e_start, e_busy, e_to;
    logic [7:0] e_data;
    int         m_owner, m_age, m_rr;

    initial begin
        m_owner = -1; m_age = 0; m_rr = 0;
        e_gnt = '0; e_done = '0; e_start = 1'b0; e_busy = 1'b0; e_to = 1'b0; e_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_owner = -1; m_rr = 0;
                e_gnt = '0; e_done = '0; e_start = 1'b0; e_busy = 1'b0; e_to = 1'b0; e_data = '0;
            end
            if (gnt[1]) gnt1_cnt++;
            if (model_on) begin
                check("cycle_outputs", outs(),
                      32'({e_gnt, e_done, e_start, e_data, e_busy, e_to}));
            end
            e_gnt = '0; e_done = '0; e_start = 1'b0; e_to = 1'b0;
            if (!rst_n) begin
                e_busy = 1'b0;
                e_data = '0;
            end else if (m_owner < 0) begin
                e_busy = 1'b0;
                for (int k = 0; k < NUM_REQ; k++) begin
                    int w;
                    w = (m_rr + k) % NUM_REQ;
                    if (m_owner < 0 && req[w]) begin
                        m_owner  = w;
                        m_age    = 0;
                        e_gnt[w] = 1'b1;
                        e_start  = 1'b1;
                        e_data   = req_data[8*w +: 8];
                        e_busy   = 1'b1;
                    end
                end
            end else begin
                m_age++;
                if (tx_done) begin
                    e_done[m_owner] = 1'b1;
                    m_rr    = (m_owner + 1) % NUM_REQ;
                    m_owner = -1;
                    e_busy  = 1'b0;
                end else if (m_age == TIMEOUT) begin
                    e_to    = 1'b1;
                    m_rr    = (m_owner + 1) % NUM_REQ;
                    m_owner = -1;
                    e_busy  = 1'b0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_gnt(input int budget, output logic [3:0] g);
        g = '0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (gnt != 4'b0) begin
                g = gnt;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_gnt: no grant within %0d cycles", budget);
    endtask

    task automatic wait_done(input int budget, output logic [3:0] d);
        d = '0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done != 4'b0 || timeout_err) begin
                d = done;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_done: no completion within %0d cycles", budget);
    endtask

    initial begin
        logic [3:0] g;
        logic [3:0] d;
        int         ord[4];
        int         fair_exp[4];
        int         n;
        int         c0;

        fair_exp = '{0, 3, 0, 3};
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 32'd0);
        model_on = 1'b1;
        rst_n    = 1'b1;
        step(2);

        // All four at once: rotate 0,1,2,3
        req_data = 32'h44332211;
        req      = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(400, g);
            ord[k] = oh2i(g);
            req    = req & ~g;
        end
        for (int k = 0; k < 4; k++) check("all4_order", 32'(ord[k]), 32'(k));
        wait_done(300, d);
        check("all4_last_done", 32'(d), 32'h8);
        step(2);

        // Requester 0 held continuously alongside 3: alternate 0,3,0,3
        req_data = 32'hC3000096;
        req      = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(400, g);
            ord[k] = oh2i(g);
            if (k == 3) req = '0;
        end
        for (int k = 0; k < 4; k++) check("fair_order", 32'(ord[k]), 32'(fair_exp[k]));
        wait_done(300, d);
        step(2);

        // Single requester 2 with 0xA5
        req_data = 32'h00A50000;
        req      = 4'b0100;
        wait_gnt(3, g);
        check("single_gnt", 32'(g), 32'h4);
        check("single_start", 32'(tx_start), 32'd1);
        check("single_data", 32'(tx_data), 32'hA5);
        check("single_frame", 32'({1'b1, tx_data, 1'b0}), 32'h34A);
        req = '0;
        wait_done(300, d);
        check("single_done", 32'(d), 32'h4);
        step(2);

        // tx_done while idle is ignored
        force_done = 1'b1;
        step(1);
        force_done = 1'b0;
        step(3);
        check("idle_txdone_busy", 32'(busy), 32'd0);

        // Watchdog: transmitter never answers
        tx_en    = 1'b0;
        req_data = 32'h99005A00;
        req      = 4'b0010;
        wait_gnt(3, g);
        check("to_gnt", 32'(g), 32'h2);
        req = 4'b1000;
        n   = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (timeout_err) break;
        end
        check("to_latency", 32'(n), 32'd400);
        check("to_no_done", 32'(done), 32'd0);
        check("to_busy_low", 32'(busy), 32'd0);
        wait_gnt(3, g);
        check("to_next_gnt", 32'(g), 32'h8);
        tx_en = 1'b1;
        req   = '0;

        // One-cycle glitch on req[1] while busy
        step(5);
        c0  = gnt1_cnt;
        req = 4'b0010;
        step(1);
        req = '0;
        wait_done(300, d);
        check("glitch_done3", 32'(d), 32'h8);
        step(3);
        check("glitch_no_gnt1", 32'(gnt1_cnt - c0), 32'd0);

        // Reset in the middle of a byte, then a clean transfer
        req_data = 32'h00000077;
        req      = 4'b0001;
        wait_gnt(3, g);
        req = '0;
        step(50);
        rst_n = 1'b0;
        #1;
        check("reset_async", outs(), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        req_data = 32'h0000003C;
        req      = 4'b0001;
        wait_gnt(3, g);
        check("post_reset_gnt", 32'(g), 32'h1);
        check("post_reset_data", 32'(tx_data), 32'h3C);
        req = '0;
        wait_done(300, d);
        check("post_reset_done", 32'(d), 32'h1);
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
